unidad_mult_div: RTL



---
 rtl/unidad_mult_div_pkg.sv | 19 +
 rtl/unidad_mult_div_div_step.sv | 22 ++
 rtl/unidad_mult_div.sv | 132 +++++++++++++
 3 files changed

// File: rtl/unidad_mult_div_pkg.sv
// Shared encodings for the iterative MIPS multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } state_e;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/unidad_mult_div_div_step.sv
// One restoring-division step: shift in the next dividend bit and try to subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // A borrow out of the top bit means the trial subtraction failed: restore.
    assign o_qbit = ~w_diff[WIDTH];
    assign o_rem  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/unidad_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 32 magnitude steps then a sign-fix cycle.
module unidad_mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    state_e           r_state;
    logic [5:0]       r_cnt;
    logic             r_is_div, r_neg_q, r_neg_r, r_div0;
    logic             r_busy, r_done;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opb;

    logic             w_is_div, w_signed;
    logic [WIDTH-1:0] w_a, w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_new_rem;
    logic             w_qbit;

    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a      = mag(operand_a, w_signed);
    assign w_b      = mag(operand_b, w_signed);

    // Multiply keeps the multiplier in the low half of the accumulator; divide keeps the dividend there.
    assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc_hi),
        .i_divisor (r_opb),
        .i_bit     (r_acc_lo[WIDTH-1]),
        .o_rem     (w_new_rem),
        .o_qbit    (w_qbit)
    );

    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_quo_s, w_rem_s, w_fix_hi, w_fix_lo;

    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo_s  = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_acc_lo : r_acc_lo);
    assign w_rem_s  = r_neg_r ? -r_acc_hi : r_acc_hi;
    assign w_fix_hi = r_is_div ? w_rem_s : w_prod_s[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo_s : w_prod_s[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        r_neg_r  <= w_signed && operand_a[WIDTH-1];
                        r_div0   <= w_is_div && (operand_b == '0);
                        r_cnt    <= 6'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ITER;
                    end else begin
                        if (mt_hi) r_hi <= mt_data;
                        if (mt_lo) r_lo <= mt_data;
                    end
                end
                ITER: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(ITER_COUNT - 1)) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= 6'd0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_acc_hi <= '0;
            r_acc_lo <= w_is_div ? w_a : w_b;
            r_opb    <= w_is_div ? w_b : w_a;
        end else if (r_state == ITER) begin
            if (r_is_div) begin
                r_acc_hi <= w_new_rem;
                r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_qbit};
            end else begin
                {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[WIDTH-1:1]};
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
